// File: rtl/pipeline_debug_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_debug_pkg : command codes, FSM states and constants for the debug controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipeline_debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_FLUSH = 8'h72;  // 'r'
  localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    STEP = 3'd2,
    LOAD = 3'd3,
    SEND = 3'd4,
    GAP  = 3'd5,
    WAIT = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_debug_ctrl_dump_serializer.sv
// ----------------------------------------------------------------------------
// dump_serializer : shifts 32-bit words out MSB-first through the UART tx handshake
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dump_serializer
  import pipeline_debug_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        last_word,
  input  logic [31:0] word_in,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        word_done
);

  state_t      state;
  state_t      state_d;
  logic [31:0] shreg;
  logic [1:0]  byte_cnt;
  logic        byte_last;

  assign byte_last = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign tx_data   = shreg[31:24];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == LOAD) begin
        shreg    <= word_in;
        byte_cnt <= '0;
      end else if (state == WAIT && !tx_busy && !byte_last) begin
        // shift only once the UART has released the current byte
        shreg    <= {shreg[23:0], 8'h00};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    tx_start  = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: if (start) state_d = LOAD;
      LOAD: if (!tx_busy) state_d = SEND;
      SEND: begin
        tx_start = 1'b1;
        state_d  = GAP;
      end
      GAP:  state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (!byte_last) begin
            state_d = SEND;
          end else begin
            word_done = 1'b1;
            state_d   = last_word ? IDLE : LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_debug_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_debug_ctrl : run/step/halt controller for the MIPS pipeline with UART snapshot dump
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_debug_ctrl
  import pipeline_debug_pkg::*;
#(
  parameter int DUMP_WORDS = 40,
  parameter int ADDR_W     = 6,
  parameter int CYCLE_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic               halt_seen,
  output logic               pipe_en,
  output logic               pipe_flush,
  output logic [ADDR_W-1:0]  dbg_addr,
  input  logic [31:0]        dbg_data,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               running
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DUMP_WORDS);

  // LOAD at this level stands for the whole dump phase; the serializer owns the substates
  state_t          state;
  state_t          state_d;
  logic            flush_d;
  logic            dump_start;
  logic            run_d;
  logic            word_done;
  logic            last_word;
  logic [ADDR_W:0] word_idx;
  logic [31:0]     word_in;

  assign last_word = (word_idx == LAST_IDX);
  assign word_in   = (word_idx == '0) ? 32'(cycle_count) : dbg_data;
  assign run_d     = (state_d == RUN) || (state_d == STEP);

  always_comb begin
    state_d    = state;
    flush_d    = 1'b0;
    dump_start = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN: begin
              if (halt_seen) begin
                state_d    = LOAD;
                dump_start = 1'b1;
              end else begin
                state_d = RUN;
              end
            end
            CMD_STEP:  state_d = STEP;
            CMD_FLUSH: flush_d = 1'b1;
            CMD_DUMP: begin
              state_d    = LOAD;
              dump_start = 1'b1;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RUN: begin
        if (halt_seen) begin
          state_d    = LOAD;
          dump_start = 1'b1;
        end
      end
      STEP: begin
        state_d    = LOAD;
        dump_start = 1'b1;
      end
      LOAD: if (word_done && last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pipe_en     <= 1'b0;
      running     <= 1'b0;
      pipe_flush  <= 1'b0;
      cycle_count <= '0;
      word_idx    <= '0;
      dbg_addr    <= '0;
    end else begin
      state      <= state_d;
      pipe_en    <= run_d;
      running    <= run_d;
      pipe_flush <= flush_d;
      if (flush_d) begin
        cycle_count <= '0;
      end else if (pipe_en) begin
        cycle_count <= cycle_count + CYCLE_W'(1);
      end
      // word 0 is the cycle count, so the read address trails the word index by one
      if (word_done) begin
        if (last_word) begin
          word_idx <= '0;
          dbg_addr <= '0;
        end else begin
          word_idx <= word_idx + (ADDR_W + 1)'(1);
          if (word_idx != '0) dbg_addr <= dbg_addr + ADDR_W'(1);
        end
      end
    end
  end

  dump_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .start     (dump_start),
    .last_word (last_word),
    .word_in   (word_in),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .word_done (word_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipeline_debug_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_debug_ctrl : directed self-checking bench with UART tx model and dump model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_debug_ctrl;

  localparam int DW     = 2;
  localparam int AW     = 6;
  localparam int CW     = 4;
  localparam int NBYTES = 4 * (DW + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic          halt_seen = 1'b0;
  logic          pipe_en;
  logic          pipe_flush;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_data;
  logic [CW-1:0] cycle_count;
  logic          running;

  int errors = 0;
  int checks = 0;

  int        busy_cycles = 2;
  int        busy_left = 0;
  logic [7:0] rxq[$];
  logic [7:0] last_dump[NBYTES];
  int        pe_cnt = 0;
  int        fl_cnt = 0;
  bit        mon_en = 1'b1;
  logic [7:0] held_data = 8'h00;
  int        exp_cc = 0;

  assign dbg_data = {26'd0, dbg_addr} * 32'h11111111;

  pipeline_debug_ctrl #(.DUMP_WORDS(DW), .ADDR_W(AW), .CYCLE_W(CW)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .halt_seen(halt_seen), .pipe_en(pipe_en), .pipe_flush(pipe_flush),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .cycle_count(cycle_count),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // UART transmitter: busy for busy_cycles cycles starting the cycle after tx_start
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
        tx_busy = 1'b1;
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_start) begin
        rxq.push_back(tx_data);
        busy_left = busy_cycles;
      end
    end
  end

  // per-cycle protocol checks
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && mon_en) begin
        chk("running_vs_pipe_en", {31'd0, running}, {31'd0, pipe_en});
        if (tx_busy) begin
          chk("no_start_while_busy", {31'd0, tx_start}, 32'd0);
          chk("tx_data_stable", {24'd0, tx_data}, {24'd0, held_data});
        end
        if (tx_start) held_data = tx_data;
        if (pipe_en) pe_cnt++;
        if (pipe_flush) fl_cnt++;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input int k, input int cc);
    logic [31:0] word;
    int w;
    int b;
    w = k / 4;
    b = k % 4;
    word = (w == 0) ? 32'(cc) : 32'(w - 1) * 32'h11111111;
    return word[31 - 8*b -: 8];
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk);
    #1;
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic dump_check(input string tag, input int cc);
    int t;
    int limit;
    t = 0;
    limit = NBYTES * (busy_cycles + 8) + 50;
    while (rxq.size() < NBYTES && t < limit) begin
      @(posedge clk);
      t++;
    end
    repeat (busy_cycles + 6) @(posedge clk);
    #1;
    chk({tag, "_len"}, 32'(rxq.size()), 32'(NBYTES));
    for (int k = 0; k < NBYTES; k++) begin
      last_dump[k] = (k < rxq.size()) ? rxq[k] : 8'hxx;
      chk({tag, "_byte"}, {24'd0, last_dump[k]}, {24'd0, exp_byte(k, cc)});
    end
    chk({tag, "_addr_zero"}, {26'd0, dbg_addr}, 32'd0);
    rxq.delete();
  endtask

  task automatic do_step(input string tag);
    pe_cnt = 0;
    send_cmd(8'h73);
    chk({tag, "_pe_on"}, {31'd0, pipe_en}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_pe_off"}, {31'd0, pipe_en}, 32'd0);
    exp_cc = (exp_cc + 1) % (1 << CW);
    dump_check(tag, exp_cc);
    chk({tag, "_pe_cycles"}, 32'(pe_cnt), 32'd1);
  endtask

  task automatic do_run(input string tag, input int h, input bit junk);
    logic [7:0] junk_codes[3];
    junk_codes[0] = 8'h64;
    junk_codes[1] = 8'h72;
    junk_codes[2] = 8'h73;
    pe_cnt = 0;
    fl_cnt = 0;
    send_cmd(8'h63);
    chk({tag, "_pe_rise"}, {31'd0, pipe_en}, 32'd1);
    for (int i = 0; i < h; i++) begin
      @(posedge clk);
      #1;
      rx_valid = junk && (i < 6) && (i % 2 == 0);
      rx_data  = junk_codes[(i / 2) % 3];
    end
    rx_valid  = 1'b0;
    halt_seen = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_pe_fall"}, {31'd0, pipe_en}, 32'd0);
    chk({tag, "_running_fall"}, {31'd0, running}, 32'd0);
    exp_cc = (exp_cc + h + 1) % (1 << CW);
    dump_check(tag, exp_cc);
    halt_seen = 1'b0;
    chk({tag, "_pe_cycles"}, 32'(pe_cnt), 32'(h + 1));
    chk({tag, "_no_flush"}, 32'(fl_cnt), 32'd0);
  endtask

  task automatic do_flush();
    fl_cnt = 0;
    send_cmd(8'h72);
    repeat (3) @(posedge clk);
    #1;
    exp_cc = 0;
    chk("flush_pulses", 32'(fl_cnt), 32'd1);
    chk("flush_count_zero", {28'd0, cycle_count}, 32'(exp_cc));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_pipe_en"}, {31'd0, pipe_en}, 32'd0);
    chk({tag, "_pipe_flush"}, {31'd0, pipe_flush}, 32'd0);
    chk({tag, "_running"}, {31'd0, running}, 32'd0);
    chk({tag, "_dbg_addr"}, {26'd0, dbg_addr}, 32'd0);
    chk({tag, "_cycle_count"}, {28'd0, cycle_count}, 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // plain dump: 00000000 | 00000000 | 11111111
    send_cmd(8'h64);
    dump_check("dump0", exp_cc);
    chk("dump0_lit_b3", {24'd0, last_dump[3]}, 32'h00);
    chk("dump0_lit_b8", {24'd0, last_dump[8]}, 32'h11);
    chk("dump0_lit_b11", {24'd0, last_dump[11]}, 32'h11);

    do_run("run11", 10, 1'b0);
    chk("run11_lit_b3", {24'd0, last_dump[3]}, 32'h0B);

    do_flush();
    do_step("step1");
    chk("step1_lit_b3", {24'd0, last_dump[3]}, 32'h01);
    do_step("step2");
    chk("step2_lit_b3", {24'd0, last_dump[3]}, 32'h02);

    // run requested while already halted: straight to dump, no pipeline activity
    halt_seen = 1'b1;
    pe_cnt = 0;
    send_cmd(8'h63);
    dump_check("halted_run", exp_cc);
    chk("halted_run_pe_cycles", 32'(pe_cnt), 32'd0);
    halt_seen = 1'b0;

    do_flush();
    send_cmd(8'h64);
    dump_check("dump_after_flush", exp_cc);

    // commands arriving during RUN are ignored
    do_run("run_junk", 12, 1'b1);

    // commands arriving during a slow dump are ignored
    busy_cycles = 50;
    pe_cnt = 0;
    fl_cnt = 0;
    send_cmd(8'h64);
    t = 0;
    while (rxq.size() < 1 && t < 200) begin
      @(posedge clk);
      t++;
    end
    send_cmd(8'h73);
    repeat (7) @(posedge clk);
    send_cmd(8'h63);
    repeat (60) @(posedge clk);
    send_cmd(8'h72);
    dump_check("slow_dump", exp_cc);
    chk("slow_dump_pe_cycles", 32'(pe_cnt), 32'd0);
    chk("slow_dump_flushes", 32'(fl_cnt), 32'd0);

    // reset in the middle of a dump
    send_cmd(8'h64);
    t = 0;
    while (rxq.size() < 2 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("mid_dump_progress", 32'(rxq.size() >= 2), 32'd1);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    exp_cc = 0;
    t = 0;
    while ((busy_left > 0 || tx_busy) && t < 200) begin
      @(posedge clk);
      t++;
    end
    rxq.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("no_tx_after_reset", 32'(rxq.size()), 32'd0);
    held_data = tx_data;
    mon_en = 1'b1;

    // cycle_count wraps from all-ones to zero
    busy_cycles = 2;
    do_flush();
    do_run("run15", 14, 1'b0);
    chk("run15_lit_b3", {24'd0, last_dump[3]}, 32'h0F);
    do_step("wrap");
    chk("wrap_lit_b3", {24'd0, last_dump[3]}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
